// File: rtl/life_ctrl_pkg.sv
// Shared types and default widths for the Life controller blocks.
package life_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } step_state_t;

    localparam int LIFE_GEN_W = 32;
    localparam int LIFE_OVR_W = 16;

endpackage : life_ctrl_pkg

// File: rtl/life_step_sequencer_sat_counter.sv
// sat_counter: up-counter with synchronous clear that holds once it reaches all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : sat_counter

// File: rtl/life_step_sequencer.sv
// Tick-to-step sequencer for the Life update engine; counts generations and, when
// LIFE_STEP_OVERRUN_EN is defined, ticks dropped while a step is in flight.
module life_step_sequencer
    import life_ctrl_pkg::*;
#(
    parameter int GEN_W = LIFE_GEN_W,
    parameter int OVR_W = LIFE_OVR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             run,
    input  logic             single,
    input  logic             step_done,
    output logic             step_start,
    output logic             busy,
    output logic [GEN_W-1:0] generation
`ifdef LIFE_STEP_OVERRUN_EN
    ,
    output logic [OVR_W-1:0] overrun
`endif
);

    if (GEN_W < 1) begin : g_gen_w_bad
        $error("GEN_W must be at least 1");
    end
    if (OVR_W < 1) begin : g_ovr_w_bad
        $error("OVR_W must be at least 1");
    end

    step_state_t      state_q;
    logic             step_start_q;
    logic             busy_q;
    logic [GEN_W-1:0] gen_q;

    // busy_q mirrors (state_q != IDLE) so every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            step_start_q <= 1'b0;
            busy_q       <= 1'b0;
            gen_q        <= '0;
        end else begin
            step_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if ((run && tick) || single) begin
                        state_q      <= START;
                        step_start_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                START: begin
                    state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (step_done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        gen_q   <= gen_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign step_start = step_start_q;
    assign busy       = busy_q;
    assign generation = gen_q;

`ifdef LIFE_STEP_OVERRUN_EN
    // A tick that cannot be accepted because a step is already in flight.
    logic ovr_inc;
    assign ovr_inc = tick && run && busy_q;

    sat_counter #(
        .WIDTH (OVR_W)
    ) u_ovr_cnt (
        .clk     (clk),
        .clr_i   (reset),
        .inc_i   (ovr_inc),
        .count_o (overrun)
    );
`endif

endmodule : life_step_sequencer

// File: tb/tb_life_step_sequencer.sv
// Scoreboard bench: a step-level reference model queues expected outputs, a monitor compares two DUT widths.
module tb_life_step_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic tick = 1'b0, run = 1'b0, single = 1'b0, step_done = 1'b0;

    logic        ss_a, busy_a;
    logic [31:0] gen_a;
    logic        ss_b, busy_b;
    logic [2:0]  gen_b;
`ifdef LIFE_STEP_OVERRUN_EN
    logic [15:0] ovr_a;
    logic [1:0]  ovr_b;
`endif

    life_step_sequencer u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .run        (run),
        .single     (single),
        .step_done  (step_done),
        .step_start (ss_a),
        .busy       (busy_a),
        .generation (gen_a)
`ifdef LIFE_STEP_OVERRUN_EN
        ,
        .overrun    (ovr_a)
`endif
    );

    life_step_sequencer #(.GEN_W(3), .OVR_W(2)) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .run        (run),
        .single     (single),
        .step_done  (step_done),
        .step_start (ss_b),
        .busy       (busy_b),
        .generation (gen_b)
`ifdef LIFE_STEP_OVERRUN_EN
        ,
        .overrun    (ovr_b)
`endif
    );

    typedef struct {
        bit     ss;
        bit     busy;
        longint gen;
        longint ovr;
    } exp_t;

    exp_t q[$];

    // Reference model: a requested step, a step in flight, and raw event counts.
    bit     m_requested = 1'b0;
    bit     m_in_flight = 1'b0;
    longint m_gen = 0;
    longint m_ovr = 0;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    endtask

    function automatic longint sat(input longint v, input longint maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic cyc(input bit r, input bit t, input bit rn, input bit s, input bit d);
        exp_t e;
        bit   was_busy;
        @(negedge clk);
        reset = r; tick = t; run = rn; single = s; step_done = d;
        if (r) begin
            m_requested = 1'b0;
            m_in_flight = 1'b0;
            m_gen = 0;
            m_ovr = 0;
        end else begin
            was_busy = m_requested || m_in_flight;
            if (was_busy && rn && t) m_ovr++;
            if (m_requested) begin
                m_requested = 1'b0;
                m_in_flight = 1'b1;
            end else if (m_in_flight) begin
                if (d) begin
                    m_in_flight = 1'b0;
                    m_gen++;
                end
            end else if ((rn && t) || s) begin
                m_requested = 1'b1;
            end
        end
        e.ss   = m_requested;
        e.busy = m_requested || m_in_flight;
        e.gen  = m_gen;
        e.ovr  = m_ovr;
        q.push_back(e);
    endtask

    task automatic idle(input int n, input bit rn);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, rn, 1'b0, 1'b0);
    endtask

    // Monitor: each expectation is checked just after the edge that should produce it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("step_start_a", longint'(ss_a), longint'(e.ss));
                chk("busy_a", longint'(busy_a), longint'(e.busy));
                chk("generation_a", longint'(gen_a), e.gen % (64'd1 << 32));
                chk("step_start_b", longint'(ss_b), longint'(e.ss));
                chk("busy_b", longint'(busy_b), longint'(e.busy));
                chk("generation_b", longint'(gen_b), e.gen % 8);
`ifdef LIFE_STEP_OVERRUN_EN
                chk("overrun_a", longint'(ovr_a), sat(e.ovr, 65535));
                chk("overrun_b", longint'(ovr_b), sat(e.ovr, 3));
`endif
            end
        end
    end

    initial begin
        bit rn;
        // Reset, then a tick-driven step completed four cycles later.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(6, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(3, 1'b1);
        // run low: ticks ignored, single still steps.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b1);
        // Busy ticks become overruns; done in START is ignored.
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        // Tick coincident with done is dropped, next tick is accepted.
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        // Tick and single together give one step; reset abandons it.
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b1);
        // Randomized traffic.
        rn = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) rn = ~rn;
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 2) == 0),
                rn,
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 2) == 0));
        end
        @(posedge clk);
        #3;
        chk("queue_drained", longint'(q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_life_step_sequencer
